// File: rtl/mac_sched.sv
// rtl/mac_sched.sv - two-channel operand scheduler with in-order result ID tagging; MAC_SCHED_PKT_LOCK_EN selects packet-locked grants
module mac_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] s0_tdata,
    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic        s0_tlast,
    input  logic [23:0] s1_tdata,
    input  logic        s1_tvalid,
    output logic        s1_tready,
    input  logic        s1_tlast,
    output logic [23:0] dp_tdata,
    output logic        dp_tvalid,
    input  logic        dp_tready,
    output logic        dp_tlast,
    input  logic [15:0] dp_res_tdata,
    input  logic        dp_res_tvalid,
    output logic        dp_res_tready,
    input  logic        dp_res_tlast,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tid,
    output logic        err_orphan
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_orphan_q, err_orphan_d;
    logic          id_mem_q [FIFO_DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic issue;
    logic pop;
    logic push_id;
    logic release_grant;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);

    // Only the granted channel sees dp_tready; a full ID FIFO blocks issue outright
    always_comb begin
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        dp_tdata  = '0;
        dp_tlast  = 1'b0;
        dp_tvalid = 1'b0;
        case (state_q)
            GRANT0: begin
                dp_tdata  = s0_tdata;
                dp_tlast  = s0_tlast;
                dp_tvalid = s0_tvalid & ~fifo_full;
                s0_tready = dp_tready & ~fifo_full;
            end
            GRANT1: begin
                dp_tdata  = s1_tdata;
                dp_tlast  = s1_tlast;
                dp_tvalid = s1_tvalid & ~fifo_full;
                s1_tready = dp_tready & ~fifo_full;
            end
            default: ;
        endcase
    end

    assign issue   = dp_tvalid & dp_tready;
    assign push_id = (state_q == GRANT1);

`ifdef MAC_SCHED_PKT_LOCK_EN
    assign release_grant = issue & dp_tlast;
`else
    assign release_grant = issue;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (s0_tvalid && s1_tvalid) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (s0_tvalid) begin
                    state_d = GRANT0;
                end else if (s1_tvalid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (release_grant) begin
                    state_d      = IDLE;
                    last_grant_d = push_id;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are tagged straight from the FIFO head; nothing is registered on this path
    assign m_tdata       = dp_res_tdata;
    assign m_tlast       = dp_res_tlast;
    assign m_tid         = id_mem_q[rd_ptr_q] & ~fifo_empty;
    assign m_tvalid      = dp_res_tvalid & ~fifo_empty;
    assign dp_res_tready = m_tready & ~fifo_empty;
    assign pop           = m_tvalid & m_tready;
    assign err_orphan    = err_orphan_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + AW'(issue);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_q + (AW+1)'(issue) - (AW+1)'(pop);
        err_orphan_d = err_orphan_q | (dp_res_tvalid & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            id_mem_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, depth of the in-flight channel-ID FIFO (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports s0_tdata/s1_tdata  input  24  operand bundles {c[23:16], b[15:8], a[7:0]}.
REQ-005 SHALL have ports s0_tvalid/s1_tvalid  input  1; s0_tready/s1_tready  output  1; s0_tlast/s1_tlast  input  1.
REQ-006 SHALL have ports dp_tdata  output  24; dp_tvalid  output  1; dp_tready  input  1; dp_tlast  output  1; these form the operand stream to the shared multiply-add datapath.
REQ-007 SHALL have ports dp_res_tdata  input  16; dp_res_tvalid  input  1; dp_res_tready  output  1; dp_res_tlast  input  1; these carry results from the datapath, in order.
REQ-008 SHALL have ports m_tdata  output  16; m_tvalid  output  1; m_tready  input  1; m_tlast  output  1; m_tid  output  1; these form the tagged result stream.
REQ-009 SHALL have port err_orphan  output  1  sticky flag: result arrived with no ID outstanding.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT0, GRANT1 plus register last_grant.
REQ-011 IDLE: if exactly one sN_tvalid=1, the FSM SHALL go to GRANTN next cycle; if both are 1, it SHALL go to the channel != last_grant; if neither, it SHALL stay in IDLE.
REQ-012 In IDLE, all s*_tready and dp_tvalid SHALL be 0; no beat is accepted in the arbitration cycle (1-cycle bubble).
REQ-013 In GRANTN: dp_tdata=sN_tdata, dp_tlast=sN_tlast, dp_tvalid=sN_tvalid & !fifo_full, sN_tready=dp_tready & !fifo_full, and the other channel's tready SHALL be 0.
REQ-014 An issue handshake (dp_tvalid & dp_tready) SHALL push N into the ID FIFO in the same cycle.
REQ-015 When the ID FIFO is full, issue SHALL be blocked, even if a pop occurs in the same cycle.
REQ-016 Grant release per Configuration; on release, the FSM SHALL go to IDLE and set last_grant=N.
REQ-017 Result path: m_tdata=dp_res_tdata, m_tlast=dp_res_tlast, m_tid=FIFO head, m_tvalid=dp_res_tvalid & !fifo_empty, dp_res_tready=m_tready & !fifo_empty (combinational, zero latency).
REQ-018 A result handshake (m_tvalid & m_tready) SHALL pop the FIFO; simultaneous push and pop SHALL leave the count unchanged.
REQ-019 If dp_res_tvalid=1 while the FIFO is empty, dp_res_tready SHALL stay 0 and err_orphan SHALL set the next cycle and remain set until rst.
REQ-020 The FIFO count SHALL range 0..FIFO_DEPTH, and read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 A source dropping sN_tvalid mid-grant SHALL NOT release the grant.

Reset
REQ-022 With rst=1 at a clock edge: state=IDLE, last_grant=1 (ch0 wins first tie), FIFO empty with pointers 0, err_orphan=0.
REQ-023 While in reset state, s*_tready, dp_tvalid, dp_res_tready and m_tvalid SHALL be 0, and m_tid SHALL be 0.
REQ-024 Reset asserted mid-packet SHALL discard all in-flight IDs; later datapath results SHALL be treated as orphans.

Configuration
REQ-025 Macro MAC_SCHED_PKT_LOCK_EN SHALL select grant behaviour.
REQ-026 When defined: the grant SHALL be held until an issue handshake with sN_tlast=1.
REQ-027 When undefined: the grant SHALL be released after every issue handshake, giving beat-level round-robin; tlast SHALL only be forwarded.

Verification
REQ-028 Reset, then s0 only, 3 beats {c=1,b=2,a=3}, tlast on the 3rd, datapath model a*b+c, m_tready=1 -> m_tdata=7 three times, m_tid=0, m_tlast on the 3rd, err_orphan=0.
REQ-029 s0 and s1 both valid from reset, 2-beat packets each, LOCK_EN defined -> issue order ch0,ch0,ch1,ch1 with one IDLE bubble between packets; m_tid sequence 0,0,1,1.
REQ-030 Same stimulus with LOCK_EN undefined -> issue order ch0,ch1,ch0,ch1; m_tid sequence 0,1,0,1.
REQ-031 FIFO_DEPTH=4, m_tready=0, datapath holds results, 6 beats offered -> exactly 4 issued, s0_tready=0 while full; raise m_tready -> remaining 2 issued after pops.
REQ-032 Pulse dp_res_tvalid=1 with no issue outstanding -> dp_res_tready=0, m_tvalid=0, err_orphan=1 next cycle and held; assert rst -> err_orphan=0.
REQ-033 Assert rst while 2 IDs are outstanding in GRANT1 -> next cycle state=IDLE, FIFO empty, s1_tready=0; a later datapath result raises err_orphan.
